// File: rtl/nios_custom_dma_pkg.sv
// Shared definitions for the Nios II DMA copy engine:
// default widths, CSR word offsets, CTRL/STAT bit positions and the FSM state type.
package nios_custom_dma_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 11;

  // CSR word offsets
  localparam logic [1:0] CSR_SRC  = 2'd0;
  localparam logic [1:0] CSR_DST  = 2'd1;
  localparam logic [1:0] CSR_LEN  = 2'd2;
  localparam logic [1:0] CSR_CTRL = 2'd3;

  // CTRL/STAT bit positions. On reads, bit 0 reports BUSY instead of GO.
  localparam int CTRL_GO   = 0;
  localparam int CTRL_DONE = 1;
  localparam int CTRL_IE   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/nios_custom_dma_csr.sv
// CSR register file for the DMA copy engine.
// It holds the SRC, DST and LEN registers and the DONE and IE flags, and drives irq.
// Ports:
//   csr_*      Avalon-MM slave. Read data is registered and valid 1 cycle after csr_read.
//   busy_i     engine is not idle. While it is high, SRC/DST/LEN writes and GO are ignored.
//   done_set_i final write retired this cycle. DONE is set on the next edge.
//   go_o       single-cycle start pulse, issued only for an accepted GO with LEN != 0.
//   src_o/dst_o/len_o  current register values, latched by the engine on go_o.
//   irq_o      DONE & IE.
module nios_custom_dma_csr
  import nios_custom_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [DATA_W-1:0] csr_writedata,
  output logic [DATA_W-1:0] csr_readdata,
  input  logic              busy_i,
  input  logic              done_set_i,
  output logic              go_o,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              irq_o
);

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic              done_q;
  logic              ie_q;
  logic [DATA_W-1:0] readdata_q;
  logic [DATA_W-1:0] rd_mux;
  logic              wr_en;
  logic              ctrl_wr;
  logic              go_acc;
  logic              len_zero;
  logic              unused_wdata;

  assign unused_wdata = ^csr_writedata[DATA_W-1:LEN_W];

  assign wr_en    = csr_chipselect & csr_write;
  assign ctrl_wr  = wr_en && (csr_address == CSR_CTRL);
  assign go_acc   = ctrl_wr && csr_writedata[CTRL_GO] && !busy_i;
  assign len_zero = (len_q == '0);
  assign go_o     = go_acc && !len_zero;

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_SRC: rd_mux[ADDR_W-1:0] = src_q;
      CSR_DST: rd_mux[ADDR_W-1:0] = dst_q;
      CSR_LEN: rd_mux[LEN_W-1:0]  = len_q;
      default: begin
        rd_mux[CTRL_GO]   = busy_i;
        rd_mux[CTRL_DONE] = done_q;
        rd_mux[CTRL_IE]   = ie_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      ie_q       <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (wr_en && !busy_i) begin
        case (csr_address)
          CSR_SRC: src_q <= csr_writedata[ADDR_W-1:0];
          CSR_DST: dst_q <= csr_writedata[ADDR_W-1:0];
          CSR_LEN: len_q <= csr_writedata[LEN_W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) ie_q <= csr_writedata[CTRL_IE];
      // Completion, or a zero-length GO, wins over a same-cycle W1C.
      // A real start clears DONE from the previous run.
      if (done_set_i || (go_acc && len_zero)) done_q <= 1'b1;
      else if (go_acc)                        done_q <= 1'b0;
      else if (ctrl_wr && csr_writedata[CTRL_DONE]) done_q <= 1'b0;
      if (csr_chipselect && csr_read) readdata_q <= rd_mux;
    end
  end

  assign csr_readdata = readdata_q;
  assign src_o        = src_q;
  assign dst_o        = dst_q;
  assign len_o        = len_q;
  assign irq_o        = done_q & ie_q;

endmodule

// File: rtl/nios_custom_dma_copy_engine.sv
// DMA copy engine top level.
// It copies LEN words from the source RAM to the destination RAM at 1 word per cycle.
// Ports:
//   csr_*  CSR slave: 0=SRC, 1=DST, 2=LEN, 3=CTRL/STAT.
//   src_*  read master on the source RAM. Read latency is 1 cycle and there is no waitrequest.
//   dst_*  write master on the destination RAM. Byte enables are always 4'hF.
//   irq    level interrupt, DONE & IE.
module nios_custom_dma_copy_engine
  import nios_custom_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [DATA_W-1:0] csr_writedata,
  output logic [DATA_W-1:0] csr_readdata,
  output logic [ADDR_W-1:0] src_address,
  output logic              src_chipselect,
  input  logic [DATA_W-1:0] src_readdata,
  output logic [ADDR_W-1:0] dst_address,
  output logic              dst_chipselect,
  output logic              dst_write,
  output logic [3:0]        dst_byteenable,
  output logic [DATA_W-1:0] dst_writedata,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              rd_valid_q;
  logic              go;
  logic              busy;
  logic [ADDR_W-1:0] cfg_src;
  logic [ADDR_W-1:0] cfg_dst;
  logic [LEN_W-1:0]  cfg_len;

  assign busy = (state_q != ST_IDLE);

  nios_custom_dma_csr #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) u_csr (
    .clk           (clk),
    .reset         (reset),
    .csr_address   (csr_address),
    .csr_chipselect(csr_chipselect),
    .csr_write     (csr_write),
    .csr_read      (csr_read),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .busy_i        (busy),
    .done_set_i    (state_q == ST_DRAIN),
    .go_o          (go),
    .src_o         (cfg_src),
    .dst_o         (cfg_dst),
    .len_o         (cfg_len),
    .irq_o         (irq)
  );

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    remain_d  = remain_q;
    wr_addr_d = wr_addr_q;
    // The write side trails the read side by exactly one cycle.
    // rd_valid_q is never set in IDLE, so a start cannot race this increment.
    if (rd_valid_q) wr_addr_d = wr_addr_q + ADDR_ONE;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d   = ST_RUN;
          rd_addr_d = cfg_src;
          wr_addr_d = cfg_dst;
          remain_d  = cfg_len;
        end
      end
      ST_RUN: begin
        rd_addr_d = rd_addr_q + ADDR_ONE;
        remain_d  = remain_q - LEN_ONE;
        if (remain_q == LEN_ONE) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      remain_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      remain_q   <= remain_d;
      rd_valid_q <= (state_q == ST_RUN);
    end
  end

  // Addresses and data are gated to 0 whenever their strobe is idle.
  assign src_chipselect = (state_q == ST_RUN);
  assign src_address    = src_chipselect ? rd_addr_q : '0;
  assign dst_chipselect = rd_valid_q;
  assign dst_write      = rd_valid_q;
  assign dst_address    = rd_valid_q ? wr_addr_q : '0;
  assign dst_writedata  = rd_valid_q ? src_readdata : '0;
  assign dst_byteenable = 4'hF;

endmodule

// File: tb/tb_nios_custom_dma_copy_engine.sv
module tb_nios_custom_dma_copy_engine;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 11;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    csr_address = '0;
  logic          csr_chipselect = 1'b0;
  logic          csr_write = 1'b0;
  logic          csr_read = 1'b0;
  logic [DW-1:0] csr_writedata = '0;
  logic [DW-1:0] csr_readdata;
  logic [AW-1:0] src_address;
  logic          src_chipselect;
  logic [DW-1:0] src_rd_q = '0;
  logic [AW-1:0] dst_address;
  logic          dst_chipselect;
  logic          dst_write;
  logic [3:0]    dst_byteenable;
  logic [DW-1:0] dst_writedata;
  logic          irq;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [DW-1:0] src_mem [0:DEPTH-1];

  // Monitored bus activity, sampled mid-cycle on the falling edge.
  logic [31:0] mon_wa[$];
  logic [31:0] mon_wd[$];
  int          mon_wc[$];
  logic [31:0] mon_ra[$];
  int          mon_rc[$];

  nios_custom_dma_copy_engine dut (
    .clk           (clk),
    .reset         (reset),
    .csr_address   (csr_address),
    .csr_chipselect(csr_chipselect),
    .csr_write     (csr_write),
    .csr_read      (csr_read),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .src_address   (src_address),
    .src_chipselect(src_chipselect),
    .src_readdata  (src_rd_q),
    .dst_address   (dst_address),
    .dst_chipselect(dst_chipselect),
    .dst_write     (dst_write),
    .dst_byteenable(dst_byteenable),
    .dst_writedata (dst_writedata),
    .irq           (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source RAM with a registered 1-cycle read.
  always @(posedge clk) if (src_chipselect) src_rd_q <= src_mem[src_address];

  always @(negedge clk) begin
    if (dst_write) begin
      mon_wa.push_back(32'(dst_address));
      mon_wd.push_back(dst_writedata);
      mon_wc.push_back(cyc);
    end
    if (src_chipselect) begin
      mon_ra.push_back(32'(src_address));
      mon_rc.push_back(cyc);
    end
  end

  task automatic clear_mon();
    mon_wa.delete(); mon_wd.delete(); mon_wc.delete();
    mon_ra.delete(); mon_rc.delete();
  endtask

  // All CSR tasks start and end at posedge+#1. The access happens in the cycle the task is called.
  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_chipselect = 1'b1; csr_write = 1'b1; csr_address = a; csr_writedata = d;
    @(posedge clk); #1;
    csr_chipselect = 1'b0; csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_chipselect = 1'b1; csr_read = 1'b1; csr_address = a;
    @(posedge clk); #1;
    csr_chipselect = 1'b0; csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic do_xfer(input int s, input int d, input int l, input int ie, input string name);
    int go;
    logic [31:0] rv;
    csr_wr(2'd0, 32'(s));
    csr_wr(2'd1, 32'(d));
    csr_wr(2'd2, 32'(l));
    clear_mon();
    go = cyc;
    csr_wr(2'd3, 32'((ie << 2) | 1));
    wait_cyc(go + l + 1);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL %s early_irq: got %b, expected 0", name, irq);
    end
    wait_cyc(go + l + 2);
    n_chk++;
    if (irq !== 1'(ie)) begin
      n_fail++; $display("FAIL %s irq_at_done: got %b, expected %0d", name, irq, ie);
    end
    n_chk++;
    if (mon_wa.size() != l || mon_ra.size() != l) begin
      n_fail++;
      $display("FAIL %s counts: got writes=%0d reads=%0d, expected %0d each", name, mon_wa.size(), mon_ra.size(), l);
    end
    for (int i = 0; i < l && i < mon_ra.size(); i++) begin
      n_chk++;
      if (mon_ra[i] !== 32'((s + i) % DEPTH) || mon_rc[i] != go + 1 + i) begin
        n_fail++;
        $display("FAIL %s read[%0d]: got addr=%0d cyc=%0d, expected addr=%0d cyc=%0d",
                 name, i, mon_ra[i], mon_rc[i] - go, (s + i) % DEPTH, 1 + i);
      end
    end
    for (int i = 0; i < l && i < mon_wa.size(); i++) begin
      n_chk++;
      if (mon_wa[i] !== 32'((d + i) % DEPTH) || mon_wd[i] !== src_mem[(s + i) % DEPTH] || mon_wc[i] != go + 2 + i) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                 name, i, mon_wa[i], mon_wd[i], mon_wc[i] - go, (d + i) % DEPTH, src_mem[(s + i) % DEPTH], 2 + i);
      end
    end
    csr_rd(2'd3, rv);
    n_chk++;
    if (rv !== 32'((ie << 2) | 2)) begin
      n_fail++; $display("FAIL %s ctrl_read: got %h, expected %h", name, rv, (ie << 2) | 2);
    end
    $display("xfer %s src=%0d dst=%0d len=%0d ie=%0d writes=%0d", name, s, d, l, ie, mon_wa.size());
  endtask

  task automatic check_outputs_zero(input string name);
    n_chk++;
    if (src_chipselect !== 1'b0 || src_address !== '0 || dst_chipselect !== 1'b0 || dst_write !== 1'b0 ||
        dst_address !== '0 || dst_writedata !== '0 || irq !== 1'b0 || csr_readdata !== '0 || dst_byteenable !== 4'hF) begin
      n_fail++;
      $display("FAIL %s outputs: got scs=%b sa=%0d dcs=%b dw=%b da=%0d dd=%h irq=%b rd=%h be=%h, expected all 0 and be=f",
               name, src_chipselect, src_address, dst_chipselect, dst_write, dst_address, dst_writedata, irq, csr_readdata, dst_byteenable);
    end
  endtask

  task automatic check_csrs_zero(input string name);
    logic [31:0] rv;
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), rv);
      n_chk++;
      if (rv !== 32'h0) begin
        n_fail++; $display("FAIL %s csr[%0d]: got %h, expected 0", name, a, rv);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    check_csrs_zero("reset");
    $display("reset check done");
  endtask

  task automatic test_csr_regs();
    logic [31:0] rv;
    csr_wr(2'd0, 32'hFFFF_FFFF); csr_rd(2'd0, rv);
    n_chk++; if (rv !== 32'h3FF) begin n_fail++; $display("FAIL src_mask: got %h, expected 3ff", rv); end
    csr_wr(2'd1, 32'hFFFF_FC05); csr_rd(2'd1, rv);
    n_chk++; if (rv !== 32'h005) begin n_fail++; $display("FAIL dst_mask: got %h, expected 005", rv); end
    csr_wr(2'd2, 32'hFFFF_FFFF); csr_rd(2'd2, rv);
    n_chk++; if (rv !== 32'h7FF) begin n_fail++; $display("FAIL len_mask: got %h, expected 7ff", rv); end
    $display("csr register masks checked");
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) src_mem[i] = 32'hA0 + 32'(i);
    do_xfer(0, 0, 4, 1, "basic");
  endtask

  task automatic test_len_zero();
    logic [31:0] rv;
    csr_wr(2'd2, 32'h0);
    clear_mon();
    csr_wr(2'd3, 32'h5);
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL len0 irq: got %b, expected 1", irq); end
    csr_rd(2'd3, rv);
    n_chk++;
    if (rv !== 32'h6) begin n_fail++; $display("FAIL len0 ctrl: got %h, expected 6", rv); end
    repeat (6) @(posedge clk);
    #1;
    n_chk++;
    if (mon_wa.size() != 0 || mon_ra.size() != 0) begin
      n_fail++; $display("FAIL len0 activity: got writes=%0d reads=%0d, expected 0", mon_wa.size(), mon_ra.size());
    end
    $display("xfer len0 writes=%0d", mon_wa.size());
  endtask

  task automatic test_wrap();
    do_xfer(1022, 1023, 3, 0, "wrap");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      do_xfer(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(1, 40)), int'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_busy_ignore();
    int go;
    logic [31:0] rv;
    csr_wr(2'd0, 32'd100);
    csr_wr(2'd1, 32'd200);
    csr_wr(2'd2, 32'd8);
    clear_mon();
    go = cyc;
    csr_wr(2'd3, 32'h1);
    wait_cyc(go + 3);
    csr_wr(2'd2, 32'd2);
    csr_wr(2'd3, 32'h1);
    wait_cyc(go + 20);
    n_chk++;
    if (mon_wa.size() != 8) begin n_fail++; $display("FAIL busy_ignore writes: got %0d, expected 8", mon_wa.size()); end
    for (int i = 0; i < mon_wa.size() && i < 8; i++) begin
      n_chk++;
      if (mon_wa[i] !== 32'(200 + i) || mon_wd[i] !== src_mem[100 + i]) begin
        n_fail++; $display("FAIL busy_ignore write[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                           i, mon_wa[i], mon_wd[i], 200 + i, src_mem[100 + i]);
      end
    end
    csr_rd(2'd2, rv);
    n_chk++;
    if (rv !== 32'd8) begin n_fail++; $display("FAIL busy_ignore len: got %0d, expected 8", rv); end
    $display("xfer busy_ignore writes=%0d", mon_wa.size());
  endtask

  task automatic test_done_priority();
    int go;
    logic [31:0] rv;
    csr_wr(2'd0, 32'd10);
    csr_wr(2'd1, 32'd20);
    csr_wr(2'd2, 32'd4);
    go = cyc;
    csr_wr(2'd3, 32'h5);
    wait_cyc(go + 5);
    csr_wr(2'd3, 32'h6);
    csr_rd(2'd3, rv);
    n_chk++;
    if (rv !== 32'h6) begin n_fail++; $display("FAIL done_prio ctrl: got %h, expected 6", rv); end
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL done_prio irq: got %b, expected 1", irq); end
    csr_wr(2'd3, 32'h2);
    csr_rd(2'd3, rv);
    n_chk++;
    if (rv !== 32'h0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL done_clear: got ctrl=%h irq=%b, expected ctrl=0 irq=0", rv, irq);
    end
    $display("xfer done_priority ctrl_after_clear=%h", rv);
  endtask

  task automatic test_reset_mid();
    int go;
    csr_wr(2'd0, 32'd300);
    csr_wr(2'd1, 32'd400);
    csr_wr(2'd2, 32'd10);
    go = cyc;
    csr_wr(2'd3, 32'h5);
    wait_cyc(go + 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_outputs_zero("reset_mid");
    clear_mon();
    check_csrs_zero("reset_mid");
    repeat (15) @(posedge clk);
    #1;
    n_chk++;
    if (mon_wa.size() != 0 || mon_ra.size() != 0) begin
      n_fail++; $display("FAIL reset_mid activity: got writes=%0d reads=%0d, expected 0", mon_wa.size(), mon_ra.size());
    end
    $display("xfer reset_mid writes_after_reset=%0d", mon_wa.size());
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) src_mem[i] = $urandom;
    test_reset();
    test_csr_regs();
    test_basic();
    test_len_zero();
    test_wrap();
    test_random();
    test_busy_ignore();
    test_done_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_custom_dma_copy_engine.md
Name: nios_custom_dma_copy_engine

Overview:
Avalon-MM copy engine that fills the on-chip destination RAM (1024 x 32, single port, 1-cycle read latency, no waitrequest) from the on-chip source RAM.
- The Nios II programs source address, destination address and length through a 4-register CSR slave, then sets GO.
- The block streams one word per cycle: a read master on the source RAM and a write master on the destination RAM.
- On completion it raises DONE and an optional IRQ.

Parameters:
ADDR_W, 10, word-address width of both RAM ports (RAM depth = 2**ADDR_W)
DATA_W, 32, data width of RAM and CSR
LEN_W, 11, width of transfer-length register in words (max 2047)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
csr_address  in  2  CSR word select: 0=SRC, 1=DST, 2=LEN, 3=CTRL/STAT
csr_chipselect  in  1  CSR select
csr_write  in  1  CSR write strobe
csr_read  in  1  CSR read strobe
csr_writedata  in  DATA_W  CSR write data
csr_readdata  out  DATA_W  CSR read data, registered, valid 1 cycle after csr_read
src_address  out  ADDR_W  source RAM word address
src_chipselect  out  1  source RAM select (read when high, write tied low)
src_readdata  in  DATA_W  source RAM data, valid the cycle after src_chipselect
dst_address  out  ADDR_W  destination RAM word address
dst_chipselect  out  1  destination RAM select
dst_write  out  1  destination RAM write strobe
dst_byteenable  out  4  constant 4'hF
dst_writedata  out  DATA_W  destination write data
irq  out  1  level interrupt = DONE & IE

Behaviour:
- Reset, synchronous: all registers 0, state IDLE, and every output 0 except dst_byteenable (always 4'hF). A reset mid-transfer aborts immediately; a partially written destination is acceptable.
- CSR map:
  - SRC[ADDR_W-1:0], DST[ADDR_W-1:0], LEN[LEN_W-1:0]: read/write; unused bits read 0.
  - CTRL/STAT write: bit0 GO (self-clearing pulse), bit1 DONE write-1-to-clear, bit2 IE.
  - CTRL/STAT read: bit0 BUSY, bit1 DONE, bit2 IE.
- Writes to SRC, DST or LEN while BUSY are ignored. GO while BUSY is ignored.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on GO with LEN!=0. Latch working counters rd_addr=SRC, wr_addr=DST, remaining=LEN. Set BUSY; clear DONE.
  - GO with LEN=0: no RAM accesses, DONE=1 on the next cycle, BUSY stays 0.
  - RUN: each cycle drive src_chipselect=1 with src_address=rd_addr, then rd_addr+=1 (mod 2**ADDR_W) and remaining-=1. A 1-cycle valid pipe (rd_valid) tracks issued reads.
  - Whenever rd_valid: dst_chipselect=dst_write=1, dst_address=wr_addr, dst_writedata=src_readdata, then wr_addr+=1 (mod 2**ADDR_W).
  - RUN -> DRAIN after issuing the read with remaining==1.
  - DRAIN: perform the final write, then -> IDLE. BUSY=0 and DONE=1 on the cycle after the final write.
- Timing: GO accepted at cycle 0 -> first read at cycle 1 -> first write at cycle 2 -> last write at cycle LEN+1 -> DONE visible at cycle LEN+2.
- Throughput: 1 word/cycle; no backpressure, since neither RAM has waitrequest.
- Address wrap: both counters wrap 1023 -> 0 independently. Overlap between source and destination is not checked (separate RAMs).
- Simultaneous events: DONE set by completion takes priority over a W1C clear in the same cycle.
- irq is combinational from registered DONE & IE. It stays high until DONE is cleared or IE is cleared.
- csr_readdata holds its last value when not reading.

Decomposition:
- Shared package nios_custom_dma_pkg holds:
  - CSR offset constants: CSR_SRC=0, CSR_DST=1, CSR_LEN=2, CSR_CTRL=3
  - control bit indices: GO=0, DONE=1, IE=2
  - FSM state enum
  - ADDR_W/DATA_W defaults
- One sub-module is natural: nios_custom_dma_csr, holding the register file, BUSY/DONE/IE logic and irq.
- The FSM and the address/length counters stay in the top level.

Test Plan:
- SRC=0, DST=0, LEN=4, IE=1, GO; source words 0..3 = 0xA0..0xA3 -> dst writes at cycles 2..5 to addresses 0..3 with 0xA0..0xA3; DONE and irq high at cycle 6; CTRL reads 0x6.
- LEN=0, GO -> no src_chipselect or dst_write ever; DONE=1 one cycle later; BUSY never set.
- SRC=1022, DST=1023, LEN=3 -> reads at 1022, 1023, 0; writes at 1023, 0, 1.
- During a LEN=8 run: write LEN=2 and GO again at cycle 3 -> both ignored; exactly 8 writes; LEN still reads 8.
- Completion cycle coincides with a CTRL write of 0x2 (clear DONE) -> DONE reads 1 afterwards. A later write of 0x2 -> DONE=0 and irq=0.
- Assert reset at cycle 3 of a LEN=10 run -> all outputs 0 the following cycle; state IDLE; SRC/DST/LEN/CTRL read 0.
